// File: rtl/one_hot_pkg.sv
// +----------------------------------------------------------------------+
// | one_hot_pkg                                                          |
// | Shared widths and encode/check helpers for the one-hot encoder.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package one_hot_pkg;

    localparam int BIN_W_DEF       = 4;
    localparam int ONE_HOT_W_DEF   = 16;
    localparam int c_ONE_HOT_MAX_W = 1024;

    // Helpers operate on the widest supported vector; callers zero-extend.
    function automatic logic [c_ONE_HOT_MAX_W-1:0] onehot_f(input int unsigned bin,
                                                            input int unsigned width);
        logic [c_ONE_HOT_MAX_W-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < c_ONE_HOT_MAX_W; k++) begin
            v[k] = (k < width) && (k == bin);
        end
        return v;
    endfunction

    function automatic logic is_onehot_f(input logic [c_ONE_HOT_MAX_W-1:0] vec);
        return ($countones(vec) == 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/one_hot_dec.sv
// +----------------------------------------------------------------------+
// | one_hot_dec                                                          |
// | Combinational binary-to-one-hot decoder with out-of-range flag.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module one_hot_dec
    import one_hot_pkg::*;
#(
    parameter int BIN_W     = BIN_W_DEF,
    parameter int ONE_HOT_W = ONE_HOT_W_DEF
) (
    input  logic [BIN_W-1:0]     bin_i,
    output logic [ONE_HOT_W-1:0] one_hot_o,
    output logic                 oor_o
);

    localparam logic [BIN_W:0] c_LIMIT = (BIN_W + 1)'(ONE_HOT_W);

    for (genvar k = 0; k < ONE_HOT_W; k++) begin : g_bit
        assign one_hot_o[k] = (bin_i == BIN_W'(k));
    end

    // Indices past the vector set no bit, so only the flag reports them.
    assign oor_o = ({1'b0, bin_i} >= c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/one_hot_encoder.sv
// +----------------------------------------------------------------------+
// | one_hot_encoder                                                      |
// | Valid-qualified one-hot encoder with optional registered output.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module one_hot_encoder
    import one_hot_pkg::*;
#(
    parameter int BIN_W     = BIN_W_DEF,
    parameter int ONE_HOT_W = ONE_HOT_W_DEF,
    parameter bit OUT_REG   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIN_W-1:0]     bin_i,
    input  logic                 valid_i,
    output logic [ONE_HOT_W-1:0] one_hot_o,
    output logic                 valid_o,
    output logic                 oor_o
);

    if (BIN_W < 1 || ONE_HOT_W < 1 || ONE_HOT_W > (1 << BIN_W) ||
        ONE_HOT_W > c_ONE_HOT_MAX_W) begin : g_param_check
        $fatal(1, "one_hot_encoder: illegal BIN_W=%0d / ONE_HOT_W=%0d", BIN_W, ONE_HOT_W);
    end

    logic [ONE_HOT_W-1:0] w_one_hot;
    logic                 w_oor;

    one_hot_dec #(
        .BIN_W     (BIN_W),
        .ONE_HOT_W (ONE_HOT_W)
    ) u_dec (
        .bin_i     (bin_i),
        .one_hot_o (w_one_hot),
        .oor_o     (w_oor)
    );

    if (OUT_REG) begin : g_reg
        logic [ONE_HOT_W-1:0] r_one_hot;
        logic                 r_oor;
        logic                 r_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_one_hot <= '0;
                r_oor     <= 1'b0;
                r_valid   <= 1'b0;
            end else begin
                r_valid <= valid_i;
                if (valid_i) begin
                    r_one_hot <= w_one_hot;
                    r_oor     <= w_oor;
                end
            end
        end

        assign one_hot_o = r_one_hot;
        assign oor_o     = r_oor;
        assign valid_o   = r_valid;
    end else begin : g_comb
        logic w_unused;
        assign w_unused  = &{1'b0, clk, rst_n};
        assign one_hot_o = w_one_hot;
        assign oor_o     = w_oor;
        assign valid_o   = valid_i;
    end

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_o && !oor_o) |-> is_onehot_f(c_ONE_HOT_MAX_W'(one_hot_o)));
    a_oor_zero: assert property (@(posedge clk) disable iff (!rst_n)
        oor_o |-> (one_hot_o == '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_one_hot_encoder.sv
// +----------------------------------------------------------------------+
// | tb_one_hot_encoder                                                   |
// | Randomised self-checking bench: registered, narrow and comb variants.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_one_hot_encoder;
    import one_hot_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  bin = '0;
    logic        valid = 1'b0;

    logic [15:0] hot16, hot_c;
    logic [9:0]  hot10;
    logic        vo16, vo10, vo_c;
    logic        oor16, oor10, oor_c;

    int n_tests = 0;
    int n_fail  = 0;

    int m_hot16 = 0, m_hot10 = 0;
    bit m_oor16 = 0, m_oor10 = 0, m_valid = 0;

    always #5 clk = ~clk;

    one_hot_encoder #(.BIN_W(4), .ONE_HOT_W(16), .OUT_REG(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bin_i(bin), .valid_i(valid),
        .one_hot_o(hot16), .valid_o(vo16), .oor_o(oor16));

    one_hot_encoder #(.BIN_W(4), .ONE_HOT_W(10), .OUT_REG(1'b1)) u_dut_oor (
        .clk(clk), .rst_n(rst_n), .bin_i(bin), .valid_i(valid),
        .one_hot_o(hot10), .valid_o(vo10), .oor_o(oor10));

    one_hot_encoder #(.BIN_W(4), .ONE_HOT_W(16), .OUT_REG(1'b0)) u_dut_comb (
        .clk(clk), .rst_n(rst_n), .bin_i(bin), .valid_i(valid),
        .one_hot_o(hot_c), .valid_o(vo_c), .oor_o(oor_c));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_enc(input int b, input int w);
        return (b < w) ? (1 << b) : 0;
    endfunction

    task automatic check_regs();
        check_eq("hot16", 32'(hot16), m_hot16);
        check_eq("valid16", 32'(vo16), 32'(m_valid));
        check_eq("oor16", 32'(oor16), 32'(m_oor16));
        check_eq("hot10", 32'(hot10), m_hot10);
        check_eq("valid10", 32'(vo10), 32'(m_valid));
        check_eq("oor10", 32'(oor10), 32'(m_oor10));
        if (vo16 && !oor16)
            check_eq("popcnt16", 32'(is_onehot_f(c_ONE_HOT_MAX_W'(hot16))), 1);
        if (vo10 && !oor10)
            check_eq("popcnt10", 32'(is_onehot_f(c_ONE_HOT_MAX_W'(hot10))), 1);
    endtask

    // Drive one input vector, check the comb variant in-cycle, then the registered ones.
    task automatic step(input int b, input bit v);
        bin   = 4'(b);
        valid = v;
        #1;
        check_eq("comb_hot", 32'(hot_c), ref_enc(b, 16));
        check_eq("comb_valid", 32'(vo_c), 32'(v));
        check_eq("comb_oor", 32'(oor_c), 0);
        @(posedge clk);
        if (!rst_n) begin
            m_hot16 = 0; m_hot10 = 0; m_oor16 = 0; m_oor10 = 0; m_valid = 0;
        end else begin
            m_valid = v;
            if (v) begin
                m_hot16 = ref_enc(b, 16);
                m_oor16 = (b >= 16);
                m_hot10 = ref_enc(b, 10);
                m_oor10 = (b >= 10);
            end
        end
        #1;
        check_regs();
    endtask

    initial begin
        logic [c_ONE_HOT_MAX_W-1:0] fn_vec;
        int b;
        bit v;

        #1 rst_n = 1'b0;
        #1;
        check_regs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(i, 1'b1);
            check_eq("sweep", 32'(hot16), 32'd1 << i);
        end

        // Outputs are non-zero here (last sweep value); reset must clear them mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_hot16", 32'(hot16), 0);
        check_eq("arst_valid16", 32'(vo16), 0);
        check_eq("arst_oor10", 32'(oor10), 0);
        step(5, 1'b1);
        rst_n = 1'b1;
        step(6, 1'b1);
        check_eq("post_rst", 32'(hot16), 32'h40);

        step(7, 1'b1);
        step(3, 1'b0);
        check_eq("hold_hot", 32'(hot16), 32'h80);
        check_eq("hold_valid", 32'(vo16), 0);

        step(12, 1'b1);
        check_eq("oor_hot", 32'(hot10), 0);
        check_eq("oor_flag", 32'(oor10), 1);
        step(9, 1'b1);
        check_eq("edge_hot", 32'(hot10), 32'h200);
        check_eq("edge_oor", 32'(oor10), 0);

        for (int i = 0; i < 1000; i++) begin
            b = int'($urandom_range(15));
            v = ($urandom_range(3) != 0);
            fn_vec = onehot_f(b, 10);
            check_eq("ref_fn", fn_vec[31:0], ref_enc(b, 10));
            step(b, v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
